uart_tx_sequencer: RTL and testbench
====================================

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning baud ticks per transmitted bit.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port tick_i  input  1  one-cycle baud tick, OVERSAMPLE per bit period.
REQ-005 SHALL have port enable_i  input  1  transmission enable (enable_TX field).
REQ-006 SHALL have port data_bits_i  input  2  uart_data_lenght_t; DBIT5..DBIT8 = 5..8 data bits.
REQ-007 SHALL have port stop_bits_i  input  1  uart_stop_bits_t; STOP1 = 1 bit, STOP2 = 2 bits.
REQ-008 SHALL have port parity_mode_i  input  1  uart_parity_mode_t, EVEN or ODD.
REQ-009 SHALL have port parity_enable_i  input  1  insert parity bit.
REQ-010 SHALL have port flow_control_i  input  1  gate frame start on CTS.
REQ-011 SHALL have port cts_n_i  input  1  clear-to-send, active-low, already synchronised.
REQ-012 SHALL have port fifo_empty_i  input  1  TX buffer empty.
REQ-013 SHALL have port fifo_data_i  input  8  TX buffer head, first-word-fall-through.
REQ-014 SHALL have port fifo_read_o  output  1  one-cycle pop of the TX buffer.
REQ-015 SHALL have port tx_o  output  1  serial line, idle high.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse, frame complete (UART_DATA_TRANSMITTED source).
REQ-017 SHALL have port idle_o  output  1  high while FSM in IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL start a frame in IDLE when enable_i=1, fifo_empty_i=0, and (flow_control_i=0 or cts_n_i=0), all in the same cycle.
REQ-020 On frame start: fifo_read_o=1 for exactly that cycle; fifo_data_i, data_bits_i, stop_bits_i, parity_mode_i, parity_enable_i latched; tick and bit counters cleared; next state START.
REQ-021 Configuration inputs SHALL be ignored mid-frame; latched values apply to the whole frame.
REQ-022 A bit period SHALL end on the cycle tick_i=1 while the tick counter equals OVERSAMPLE-1; the counter then wraps to 0; cycles without tick_i hold it.
REQ-023 tx_o SHALL be registered: START drives 0; DATA drives latched data LSB first; PARITY drives parity bit; STOP and IDLE drive 1.
REQ-024 DATA SHALL last N bit periods, N = 5/6/7/8 per latched data_bits; data bits above N-1 are never transmitted.
REQ-025 Parity SHALL be XOR of the N transmitted bits for EVEN and its inverse for ODD; PARITY is skipped when parity_enable is 0.
REQ-026 STOP SHALL last 1 or 2 bit periods per latched stop_bits.
REQ-027 At the end of the final stop period: done_o=1 for one cycle, state IDLE.
REQ-028 A new frame MAY start on the cycle after done_o; there SHALL be no extra idle bit.
REQ-029 Deasserting enable_i, or CTS going high, mid-frame SHALL NOT abort the frame; both only gate the next start.
REQ-030 fifo_read_o SHALL never assert when fifo_empty_i=1 or outside IDLE.

Reset
REQ-031 On rst_n_i=0, asynchronously: state IDLE, tx_o=1, fifo_read_o=0, done_o=0, idle_o=1, counters 0, latched data 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no done_o; after release the popped byte is not retransmitted.

Verification
REQ-033 8N1, EVEN, no flow control, FIFO holds 0xA5 -> one fifo_read_o; tx_o = 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; then done_o pulse.
REQ-034 DBIT7, parity ODD, STOP2, data 0xFF -> 0, seven 1s, parity 0, two 1s; bit 7 not sent; 11 bit periods total.
REQ-035 flow_control_i=1, cts_n_i=1, FIFO non-empty -> no fifo_read_o, tx_o stays 1; drive cts_n_i=0 -> frame starts the same cycle; raise cts_n_i mid-DATA -> frame completes.
REQ-036 Two bytes 0x01, 0x80 queued, 5N1 -> frames back-to-back; second start bit begins the cycle after the first done_o; 0x80 is sent as five 0s.
REQ-037 rst_n_i pulsed low during DATA bit 3 -> tx_o=1 immediately, no done_o; after release with FIFO empty -> idle_o=1, tx_o=1.
REQ-038 Config inputs toggled mid-frame (data_bits, parity, stop) -> frame shape matches values latched at start.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops one byte per frame from a FWFT buffer and serialises it
// as start / 5..8 data / optional parity / 1..2 stop bits, paced by an oversampled baud tick.
module uart_tx_sequencer #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       tick_i,
   input  logic       enable_i,
   input  logic [1:0] data_bits_i,
   input  logic       stop_bits_i,
   input  logic       parity_mode_i,
   input  logic       parity_enable_i,
   input  logic       flow_control_i,
   input  logic       cts_n_i,
   input  logic       fifo_empty_i,
   input  logic [7:0] fifo_data_i,
   output logic       fifo_read_o,
   output logic       tx_o,
   output logic       done_o,
   output logic       idle_o
);

   localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TickMax = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    data_q, data_d;
   logic [1:0]    dbits_q, dbits_d;
   logic          stop2_q, stop2_d;
   logic          podd_q, podd_d;
   logic          pen_q, pen_d;
   logic          tx_q, tx_d;
   logic          done_q, done_d;

   logic       start_ok;
   logic       bit_end;
   logic       last_data;
   logic [7:0] data_mask;
   logic       parity_bit;

   assign start_ok = (state_q == StIdle) && enable_i && !fifo_empty_i &&
                     (!flow_control_i || !cts_n_i);
   assign bit_end  = tick_i && (tick_cnt_q == TickMax);
   // Index of the last data bit is N-1 = 4 + data_bits code.
   assign last_data  = (bit_cnt_q == {1'b1, dbits_q});
   assign data_mask  = 8'hFF >> (2'd3 - dbits_q);
   assign parity_bit = (^(data_q & data_mask)) ^ podd_q;

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      dbits_d    = dbits_q;
      stop2_d    = stop2_q;
      podd_d     = podd_q;
      pen_d      = pen_q;
      tx_d       = tx_q;
      done_d     = 1'b0;

      if (state_q != StIdle && tick_i) begin
         tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
      end

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (start_ok) begin
               data_d     = fifo_data_i;
               dbits_d    = data_bits_i;
               stop2_d    = stop_bits_i;
               podd_d     = parity_mode_i;
               pen_d      = parity_enable_i;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               tx_d       = 1'b0;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               tx_d      = data_q[0];
               state_d   = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (!last_data) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = data_q[bit_cnt_d];
               end else if (pen_q) begin
                  tx_d    = parity_bit;
                  state_d = StParity;
               end else begin
                  bit_cnt_d = '0;
                  tx_d      = 1'b1;
                  state_d   = StStop;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               tx_d      = 1'b1;
               state_d   = StStop;
            end
         end
         StStop: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (stop2_q && bit_cnt_q == 3'd0) begin
                  bit_cnt_d = 3'd1;
               end else begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         dbits_q    <= '0;
         stop2_q    <= 1'b0;
         podd_q     <= 1'b0;
         pen_q      <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         dbits_q    <= dbits_d;
         stop2_q    <= stop2_d;
         podd_q     <= podd_d;
         pen_q      <= pen_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   // Pop is combinational so a start is visible in the same cycle CTS drops; held off in reset.
   assign fifo_read_o = start_ok && rst_n_i;
   assign tx_o        = tx_q;
   assign done_o      = done_q;
   assign idle_o      = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: table of frame shapes plus hand-written
// flow-control, back-to-back and reset sequences, checked through a frame scoreboard.
module tb_uart_tx_sequencer;

   localparam int OS  = 16;
   localparam int CPB = OS * 3;  // clock cycles per bit: one tick every third cycle

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_i = 1'b0;
   logic       enable_i = 1'b0;
   logic [1:0] data_bits_i = 2'd3;
   logic       stop_bits_i = 1'b0;
   logic       parity_mode_i = 1'b0;
   logic       parity_enable_i = 1'b0;
   logic       flow_control_i = 1'b0;
   logic       cts_n_i = 1'b0;
   logic       fifo_empty_i = 1'b1;
   logic [7:0] fifo_data_i = 8'h00;
   logic       fifo_read_o, tx_o, done_o, idle_o;

   uart_tx_sequencer #(.OVERSAMPLE(OS)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .tick_i         (tick_i),
      .enable_i       (enable_i),
      .data_bits_i    (data_bits_i),
      .stop_bits_i    (stop_bits_i),
      .parity_mode_i  (parity_mode_i),
      .parity_enable_i(parity_enable_i),
      .flow_control_i (flow_control_i),
      .cts_n_i        (cts_n_i),
      .fifo_empty_i   (fifo_empty_i),
      .fifo_data_i    (fifo_data_i),
      .fifo_read_o    (fifo_read_o),
      .tx_o           (tx_o),
      .done_o         (done_o),
      .idle_o         (idle_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          n;
      logic [15:0] bits;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] dbits;
      logic       stop2;
      logic       pen;
      logic       podd;
      logic       par;
      int         len;
   } vec_t;

   frame_t     sb[$];
   logic [7:0] fq[$];
   bit         allow_unscored = 1'b0;
   int         reads = 0;
   int         dones = 0;
   int         frames_seen = 0;
   logic       rd_pre = 1'b0;
   int         tdiv = 0;

   function automatic frame_t mk(input logic [7:0] d, input int nd, input bit pen,
                                 input logic par, input int len);
      frame_t f;
      f.bits    = '1;
      f.bits[0] = 1'b0;
      for (int i = 0; i < nd; i++) f.bits[1+i] = d[i];
      if (pen) f.bits[1+nd] = par;
      f.n = len;
      return f;
   endfunction

   always @(negedge clk) begin
      tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
      tick_i = (tdiv == 0);
   end

   always @(negedge clk) begin
      #4;
      rd_pre = fifo_read_o;
      if (fifo_read_o) begin
         reads++;
         check("read_while_empty", 32'(fifo_empty_i), 32'd0);
         check("read_outside_idle", 32'(idle_o), 32'd1);
      end
   end

   // FIFO model: pop after the edge that consumed the head, then present the new head.
   always @(posedge clk) begin
      #1;
      if (rd_pre && fq.size() > 0) void'(fq.pop_front());
      fifo_empty_i = (fq.size() == 0);
      fifo_data_i  = (fq.size() != 0) ? fq[0] : 8'h00;
      if (done_o) dones++;
   end

   always begin : monitor
      frame_t      f;
      logic [15:0] got;
      @(negedge tx_o);
      if (sb.size() == 0) begin
         if (!allow_unscored) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got start bit expected none");
         end
         for (int i = 0; i < 20 * CPB; i++) begin
            @(posedge clk);
            if (idle_o) break;
         end
      end else begin
         f   = sb.pop_front();
         got = '1;
         repeat (CPB / 2) @(posedge clk);
         #1 got[0] = tx_o;
         for (int i = 1; i < f.n; i++) begin
            repeat (CPB) @(posedge clk);
            #1 got[i] = tx_o;
         end
         frames_seen++;
         check($sformatf("frame%0d_bits", frames_seen), 32'(got), 32'(f.bits));
      end
   end

   task automatic wait_reads(input int target, input int budget);
      for (int i = 0; i < budget && reads < target; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      for (int i = 0; i < budget && dones < target; i++) @(posedge clk);
      #2;
      check(name, 32'(dones), 32'(target));
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int r0, d0;
      @(negedge clk);
      data_bits_i     = v.dbits;
      stop_bits_i     = v.stop2;
      parity_enable_i = v.pen;
      parity_mode_i   = v.podd;
      flow_control_i  = 1'b0;
      enable_i        = 1'b1;
      r0 = reads;
      d0 = dones;
      sb.push_back(mk(v.data, 5 + int'(v.dbits), v.pen, v.par, v.len));
      fq.push_back(v.data);
      wait_reads(r0 + 1, 20);
      repeat (2 * CPB) @(posedge clk);
      @(negedge clk);
      data_bits_i     = ~v.dbits;
      stop_bits_i     = ~v.stop2;
      parity_enable_i = ~v.pen;
      parity_mode_i   = ~v.podd;
      enable_i        = 1'b0;
      wait_done(d0 + 1, 15 * CPB, $sformatf("vec%0d_done", idx));
      check($sformatf("vec%0d_reads", idx), 32'(reads - r0), 32'd1);
   endtask

   vec_t tbl[5];

   initial begin
      int r0, d0;
      tbl[0] = '{data: 8'hA5, dbits: 2'd3, stop2: 1'b0, pen: 1'b0, podd: 1'b0, par: 1'b0, len: 10};
      tbl[1] = '{data: 8'hFF, dbits: 2'd2, stop2: 1'b1, pen: 1'b1, podd: 1'b1, par: 1'b0, len: 11};
      tbl[2] = '{data: 8'h3C, dbits: 2'd1, stop2: 1'b0, pen: 1'b1, podd: 1'b0, par: 1'b0, len: 9};
      tbl[3] = '{data: 8'h5A, dbits: 2'd3, stop2: 1'b1, pen: 1'b1, podd: 1'b1, par: 1'b1, len: 12};
      tbl[4] = '{data: 8'h13, dbits: 2'd0, stop2: 1'b1, pen: 1'b1, podd: 1'b0, par: 1'b1, len: 9};

      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx_o), 32'd1);
      check("rst_idle", 32'(idle_o), 32'd1);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_read", 32'(fifo_read_o), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_tx", 32'(tx_o), 32'd1);

      for (int k = 0; k < 5; k++) run_frame(tbl[k], k);

      // Flow control gates the start; CTS rising mid-frame does not abort it.
      @(negedge clk);
      data_bits_i = 2'd3; stop_bits_i = 1'b0; parity_enable_i = 1'b0;
      flow_control_i = 1'b1; cts_n_i = 1'b1; enable_i = 1'b1;
      r0 = reads;
      d0 = dones;
      sb.push_back(mk(8'hC3, 8, 1'b0, 1'b0, 10));
      fq.push_back(8'hC3);
      repeat (200) @(posedge clk);
      #2;
      check("cts_gate_reads", 32'(reads - r0), 32'd0);
      check("cts_gate_tx", 32'(tx_o), 32'd1);
      @(negedge clk);
      cts_n_i = 1'b0;
      #1 check("cts_start_same_cycle", 32'(fifo_read_o), 32'd1);
      repeat (4 * CPB) @(posedge clk);
      @(negedge clk);
      cts_n_i = 1'b1;
      wait_done(d0 + 1, 15 * CPB, "cts_done");
      @(negedge clk);
      flow_control_i = 1'b0; cts_n_i = 1'b0;

      // Back-to-back 5N1 frames: second start bit on the cycle after done_o.
      data_bits_i = 2'd0; stop_bits_i = 1'b0; parity_enable_i = 1'b0; enable_i = 1'b1;
      r0 = reads;
      d0 = dones;
      sb.push_back(mk(8'h01, 5, 1'b0, 1'b0, 7));
      sb.push_back(mk(8'h80, 5, 1'b0, 1'b0, 7));
      fq.push_back(8'h01);
      fq.push_back(8'h80);
      for (int i = 0; i < 12 * CPB; i++) begin
         @(posedge clk);
         #3;
         if (done_o) break;
      end
      check("b2b_first_done", 32'(done_o), 32'd1);
      check("b2b_pop_with_done", 32'(fifo_read_o), 32'd1);
      @(posedge clk);
      #3 check("b2b_start_next_cycle", 32'(tx_o), 32'd0);
      wait_done(d0 + 2, 12 * CPB, "b2b_second_done");
      check("b2b_reads", 32'(reads - r0), 32'd2);

      // Reset during data bit 3 abandons the frame.
      @(negedge clk);
      data_bits_i = 2'd3; stop_bits_i = 1'b0; parity_enable_i = 1'b0; enable_i = 1'b1;
      allow_unscored = 1'b1;
      r0 = reads;
      fq.push_back(8'hA5);
      wait_reads(r0 + 1, 20);
      repeat (215) @(posedge clk);
      @(negedge clk);
      check("pre_rst_bit3", 32'(tx_o), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx", 32'(tx_o), 32'd1);
      check("rst_mid_idle", 32'(idle_o), 32'd1);
      check("rst_mid_done", 32'(done_o), 32'd0);
      d0 = dones;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * CPB) @(posedge clk);
      #2;
      check("rst_no_done", 32'(dones - d0), 32'd0);
      check("rst_after_tx", 32'(tx_o), 32'd1);
      check("rst_after_idle", 32'(idle_o), 32'd1);
      check("rst_no_repop", 32'(reads - r0), 32'd1);
      allow_unscored = 1'b0;

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
